// File: rtl/countdown_timer.sv
// Programmable countdown timer: loadable length, one-shot or auto-reload,
// pause/abort, optional retrigger, one-cycle expiry pulse and saturating expiry count.
module countdown_timer #(
    parameter int WIDTH     = 5,
    parameter int CNT_W     = 4,
    parameter int RETRIGGER = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             ready,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] exp_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam bit RETRIG = (RETRIGGER != 0);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic [WIDTH-1:0]   reload_reg, reload_next;
    logic               mode_reg, mode_next;
    logic [CNT_W-1:0]   exp_reg, exp_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               ready_reg, busy_reg, paused_reg;

    logic               load_ok;
    logic [CNT_W-1:0]   exp_inc;

    assign load_ok = (load_val != '0);
    assign exp_inc = (exp_reg == {CNT_W{1'b1}}) ? exp_reg : exp_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            q_reg      <= '0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            exp_reg    <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            paused_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            q_reg      <= q_next;
            reload_reg <= reload_next;
            mode_reg   <= mode_next;
            exp_reg    <= exp_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            ready_reg  <= (state_next == IDLE);
            busy_reg   <= (state_next == RUN) || (state_next == HOLD);
            paused_reg <= (state_next == HOLD);
        end
    end

    always_comb begin
        state_next  = state_reg;
        q_next      = q_reg;
        reload_next = reload_reg;
        mode_next   = mode_reg;
        exp_next    = exp_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (load_ok) begin
                        q_next      = load_val;
                        reload_next = load_val;
                        mode_next   = auto_reload;
                        exp_next    = '0;
                        state_next  = RUN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            default: begin
                if (abort) begin
                    q_next     = '0;
                    state_next = IDLE;
                end else if (RETRIG && start && load_ok) begin
                    // Retrigger reloads like a fresh start but keeps the expiry history.
                    q_next      = load_val;
                    reload_next = load_val;
                    mode_next   = auto_reload;
                    state_next  = RUN;
                end else begin
                    if (RETRIG && start) begin
                        err_next = 1'b1;
                    end
                    if (pause) begin
                        state_next = HOLD;
                    end else if (q_reg > WIDTH'(1)) begin
                        // Leaving HOLD decrements on the same edge that sees pause low.
                        q_next     = q_reg - WIDTH'(1);
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                        exp_next  = exp_inc;
                        if (mode_reg) begin
                            q_next     = reload_reg;
                            state_next = RUN;
                        end else begin
                            q_next     = '0;
                            state_next = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    assign q       = q_reg;
    assign ready   = ready_reg;
    assign busy    = busy_reg;
    assign paused  = paused_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign exp_cnt = exp_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: three instances (no retrigger, retrigger,
// 2-bit expiry counter) share stimulus; expected outputs are queued per edge.
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] load_val;
    logic       auto_reload;
    logic       pause;
    logic       abort;

    logic [4:0] q0, q1, q2;
    logic       ready0, ready1, ready2;
    logic       busy0, busy1, busy2;
    logic       paused0, paused1, paused2;
    logic       done0, done1, done2;
    logic       err0, err1, err2;
    logic [3:0] ec0, ec1;
    logic [1:0] ec2;

    typedef struct packed {
        logic [4:0] q;
        logic       rdy;
        logic       bsy;
        logic       pau;
        logic       dn;
        logic       er;
        logic [3:0] ec;
    } obs_t;

    typedef struct {
        int   cyc;
        int   d;
        obs_t o;
    } item_t;

    obs_t  obs0, obs1, obs2;
    item_t sb[$];
    int    edge_cnt = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    assign obs0 = {q0, ready0, busy0, paused0, done0, err0, ec0};
    assign obs1 = {q1, ready1, busy1, paused1, done1, err1, ec1};
    assign obs2 = {q2, ready2, busy2, paused2, done2, err2, 2'b00, ec2};

    countdown_timer #(.WIDTH(5), .CNT_W(4), .RETRIGGER(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val),
        .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .q(q0), .ready(ready0), .busy(busy0), .paused(paused0),
        .done(done0), .err(err0), .exp_cnt(ec0));

    countdown_timer #(.WIDTH(5), .CNT_W(4), .RETRIGGER(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val),
        .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .q(q1), .ready(ready1), .busy(busy1), .paused(paused1),
        .done(done1), .err(err1), .exp_cnt(ec1));

    countdown_timer #(.WIDTH(5), .CNT_W(2), .RETRIGGER(0)) dut2 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val),
        .auto_reload(auto_reload), .pause(pause), .abort(abort),
        .q(q2), .ready(ready2), .busy(busy2), .paused(paused2),
        .done(done2), .err(err2), .exp_cnt(ec2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t get_obs(input int d);
        case (d)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".q"},       int'(a.q),   int'(e.q));
        chk({tag, ".ready"},   int'(a.rdy), int'(e.rdy));
        chk({tag, ".busy"},    int'(a.bsy), int'(e.bsy));
        chk({tag, ".paused"},  int'(a.pau), int'(e.pau));
        chk({tag, ".done"},    int'(a.dn),  int'(e.dn));
        chk({tag, ".err"},     int'(a.er),  int'(e.er));
        chk({tag, ".exp_cnt"}, int'(a.ec),  int'(e.ec));
    endtask

    function automatic obs_t mk(input int qv, input int rdy, input int bsy, input int pau,
                                input int dn, input int er, input int ec);
        obs_t o;
        o.q   = 5'(qv);
        o.rdy = 1'(rdy);
        o.bsy = 1'(bsy);
        o.pau = 1'(pau);
        o.dn  = 1'(dn);
        o.er  = 1'(er);
        o.ec  = 4'(ec);
        return o;
    endfunction

    // Monitor: one transaction per instance per edge that has a queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                item_t it;
                obs_t  a;
                it = sb.pop_front();
                a  = get_obs(it.d);
                $display("edge %0d dut%0d q=%0d ready=%b busy=%b paused=%b done=%b err=%b exp_cnt=%0d",
                         edge_cnt, it.d, a.q, a.rdy, a.bsy, a.pau, a.dn, a.er, a.ec);
                chk_obs($sformatf("e%0d_dut%0d", it.cyc, it.d), a, it.o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input int s, input int lv, input int ar, input int p, input int ab);
        @(negedge clk);
        start       = 1'(s);
        load_val    = 5'(lv);
        auto_reload = 1'(ar);
        pause       = 1'(p);
        abort       = 1'(ab);
    endtask

    task automatic ex(input int d, input int qv, input int rdy, input int bsy, input int pau,
                      input int dn, input int er, input int ec);
        item_t it;
        it.cyc = edge_cnt + 1;
        it.d   = d;
        it.o   = mk(qv, rdy, bsy, pau, dn, er, ec);
        sb.push_back(it);
    endtask

    task automatic ex_all(input int qv, input int rdy, input int bsy, input int pau,
                          input int dn, input int er, input int ec);
        for (int d = 0; d < 3; d++) ex(d, qv, rdy, bsy, pau, dn, er, ec);
    endtask

    task automatic rel();
        @(negedge clk);
        rst = 1'b1;
        ex_all(0, 1, 0, 0, 0, 0, 0);
    endtask

    int q1s [6] = '{5, 4, 3, 2, 1, 0};
    int q0s [6] = '{3, 2, 1, 3, 2, 1};
    int ec0s[6] = '{2, 2, 2, 3, 3, 3};

    initial begin
        rst = 1'b0; start = 1'b0; load_val = '0; auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;

        // Reset state, then pause/abort in IDLE have no effect
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 0, 0, 0);
        rel();
        step(0, 0, 0, 1, 1); ex_all(0, 1, 0, 0, 0, 0, 0);

        // One-shot, N=8
        step(1, 8, 0, 0, 0); ex_all(8, 0, 1, 0, 0, 0, 0);
        for (int j = 1; j <= 7; j++) begin
            step(0, 0, 0, 0, 0); ex_all(8 - j, 0, 1, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 0, 0, 1);

        // Auto-reload, N=3, then abort
        step(1, 3, 1, 0, 0); ex_all(3, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            int r;
            r = i % 3;
            step(0, 0, 0, 0, 0);
            ex_all((r == 0) ? 3 : 3 - r, 0, 1, 0, (r == 0) ? 1 : 0, 0, i / 3);
        end
        step(0, 0, 0, 0, 1); ex_all(0, 1, 0, 0, 0, 0, 3);

        // Auto-reload, N=2, expiry counter saturation on the 2-bit instance
        step(1, 2, 1, 0, 0); ex_all(2, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            int qv, dn;
            qv = (i % 2 == 0) ? 2 : 1;
            dn = (i % 2 == 0) ? 1 : 0;
            step(0, 0, 0, 0, 0);
            ex(0, qv, 0, 1, 0, dn, 0, i / 2);
            ex(1, qv, 0, 1, 0, dn, 0, i / 2);
            ex(2, qv, 0, 1, 0, dn, 0, (i / 2 > 3) ? 3 : i / 2);
        end
        step(0, 0, 0, 0, 1);
        ex(0, 0, 1, 0, 0, 0, 0, 10);
        ex(1, 0, 1, 0, 0, 0, 0, 10);
        ex(2, 0, 1, 0, 0, 0, 0, 3);

        // Pause for 4 cycles at q=3 with N=5
        step(1, 5, 0, 0, 0); ex_all(5, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(4, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(3, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0); ex_all(3, 0, 1, 1, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0); ex_all(2, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 0, 0, 1);

        // Start at q=2 in auto mode: retrigger reloads, non-retrigger ignores it
        step(1, 3, 1, 0, 0); ex_all(3, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(2, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(3, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0); ex_all(2, 0, 1, 0, 0, 0, 1);
        step(1, 6, 0, 0, 0);
        ex(0, 1, 0, 1, 0, 0, 0, 1);
        ex(1, 6, 0, 1, 0, 0, 0, 1);
        ex(2, 1, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            ex(0, q0s[i], 0, 1, 0, (q0s[i] == 3) ? 1 : 0, 0, ec0s[i]);
            ex(2, q0s[i], 0, 1, 0, (q0s[i] == 3) ? 1 : 0, 0, ec0s[i]);
            ex(1, q1s[i], (i == 5) ? 1 : 0, (i == 5) ? 0 : 1, 0, (i == 5) ? 1 : 0, 0,
               (i == 5) ? 2 : 1);
        end
        step(0, 0, 0, 0, 1);
        ex(0, 0, 1, 0, 0, 0, 0, 3);
        ex(1, 0, 1, 0, 0, 0, 0, 2);
        ex(2, 0, 1, 0, 0, 0, 0, 3);

        // Start on the expiry edge: retrigger wins without done
        step(1, 2, 0, 0, 0); ex_all(2, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(1, 0, 1, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        ex(0, 0, 1, 0, 0, 1, 0, 1);
        ex(1, 4, 0, 1, 0, 0, 0, 0);
        ex(2, 0, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        ex(0, 0, 1, 0, 0, 0, 0, 1);
        ex(1, 0, 1, 0, 0, 0, 0, 0);
        ex(2, 0, 1, 0, 0, 0, 0, 1);

        // Zero-length start in IDLE gives a single err pulse
        step(1, 0, 0, 0, 0);
        ex(0, 0, 1, 0, 0, 0, 1, 1);
        ex(1, 0, 1, 0, 0, 0, 1, 0);
        ex(2, 0, 1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        ex(0, 0, 1, 0, 0, 0, 0, 1);
        ex(1, 0, 1, 0, 0, 0, 0, 0);
        ex(2, 0, 1, 0, 0, 0, 0, 1);

        // Abort at q=4
        step(1, 6, 0, 0, 0); ex_all(6, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(5, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(4, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1); ex_all(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run, right after an expiry pulse
        step(1, 2, 1, 0, 0); ex_all(2, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); ex_all(2, 0, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0); ex_all(1, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0); ex_all(2, 0, 1, 0, 1, 0, 2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            $display("async reset dut%0d q=%0d done=%b exp_cnt=%0d",
                     d, get_obs(d).q, get_obs(d).dn, get_obs(d).ec);
            chk_obs($sformatf("async_rst_dut%0d", d), get_obs(d), mk(0, 1, 0, 0, 0, 0, 0));
        end
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 0, 0, 0);
        rel();
        step(0, 0, 0, 0, 0); ex_all(0, 1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
